// File: rtl/rvv_pkg.sv
// Shared vector ALU definitions: sequencer FSM states,
// opcode and operand-type constants, chunk geometry helpers.
package rvv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    localparam logic [5:0] OP_VADD  = 6'b000000;
    localparam logic [5:0] OP_VSUB  = 6'b000010;
    localparam logic [5:0] OP_VRSUB = 6'b000011;
    localparam logic [5:0] OP_VMINU = 6'b000100;
    localparam logic [5:0] OP_VMIN  = 6'b000101;
    localparam logic [5:0] OP_VMAXU = 6'b000110;
    localparam logic [5:0] OP_VMAX  = 6'b000111;
    localparam logic [5:0] OP_VAND  = 6'b001001;
    localparam logic [5:0] OP_VOR   = 6'b001010;
    localparam logic [5:0] OP_VXOR  = 6'b001011;

    localparam logic [2:0] OPT_VV = 3'b001;
    localparam logic [2:0] OPT_VX = 3'b010;
    localparam logic [2:0] OPT_VI = 3'b100;

    // Index of the last chunk of an element (NCH-1).
    function automatic logic [3:0] nch_last(
        input logic [2:0] vsew,
        input int         lane_width
    );
        int sh;
        sh = int'(vsew) + 3 - lane_width;
        if (sh <= 0) return 4'd0;
        return 4'((1 << sh) - 1);
    endfunction

    // log2 of the chunk width: min(lane, SEW).
    function automatic logic [2:0] cw_log2(
        input logic [2:0] vsew,
        input int         lane_width
    );
        logic [2:0] sew_log2;
        sew_log2 = vsew + 3'd3;
        if (int'(sew_log2) < lane_width) return sew_log2;
        return 3'(lane_width);
    endfunction

endpackage

// File: rtl/rvv_vd_merge.sv
// Destination buffer: loads vd_old on accept, then merges
// CW-bit chunk results at an arbitrary bit index.
// Ports: clk, resetn, load, vd_old, wr_en, wr_cw_log2,
//        wr_data, wr_index -> vd.
module rvv_vd_merge #(
    parameter int VLEN = 128
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic [VLEN-1:0] vd_old,
    input  logic            wr_en,
    input  logic [2:0]      wr_cw_log2,
    input  logic [63:0]     wr_data,
    input  logic [9:0]      wr_index,
    output logic [VLEN-1:0] vd
);

    logic [63:0]      lane_mask;
    logic [VLEN+63:0] data_w;
    logic [VLEN+63:0] mask_w;

    always_comb begin
        lane_mask = '1;
        if (wr_cw_log2 < 3'd6) begin
            lane_mask = (64'd1 << (64'd1 << wr_cw_log2))
                      - 64'd1;
        end
        // Widen before shifting so a chunk near the top
        // cannot wrap into low bits.
        data_w = {{VLEN{1'b0}}, wr_data & lane_mask}
               << wr_index;
        mask_w = {{VLEN{1'b0}}, lane_mask} << wr_index;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vd <= '0;
        end else if (load) begin
            vd <= vd_old;
        end else if (wr_en) begin
            vd <= (vd & ~mask_w[VLEN-1:0])
                | data_w[VLEN-1:0];
        end
    end

endmodule

// File: rtl/rvv_alu_seq.sv
// Sequencer walking one rvv_alu lane over every active
// element/chunk of a vector instruction, merging results.
// Ports: start/opcode/op_type/vsew/vl/vd_old in; busy,
//        done, err, vd_out, alu_* drive out; alu_vd and
//        alu_index back from the ALU.
// Option: RVV_ALU_SEQ_MASK_EN adds vm and v0_mask inputs.
module rvv_alu_seq
    import rvv_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [5:0]      opcode,
    input  logic [2:0]      op_type,
    input  logic [2:0]      vsew,
    input  logic [9:0]      vl,
    input  logic [VLEN-1:0] vd_old,
`ifdef RVV_ALU_SEQ_MASK_EN
    input  logic              vm,
    input  logic [VLEN/8-1:0] v0_mask,
`endif
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [VLEN-1:0] vd_out,
    output logic            alu_run,
    output logic [5:0]      alu_opcode,
    output logic [2:0]      alu_op_type,
    output logic [2:0]      alu_vsew,
    output logic [9:0]      alu_byte_i,
    output logic [3:0]      alu_in_reg_offset,
    input  logic [63:0]     alu_vd,
    input  logic [9:0]      alu_index
);

    seq_state_e state_q, state_d;

    logic [9:0] elem_q;
    logic [9:0] vle_q;
    logic [3:0] chunk_q;
    logic [3:0] chunk_last_q;
    logic [5:0] opcode_q;
    logic [2:0] op_type_q;
    logic [2:0] vsew_q;
    logic       err_q;

    logic [10:0] vlmax;
    logic [9:0]  vle_d;
    logic        accept;
    logic        bad_sew;
    logic        last_elem;
    logic        skip;
    logic        elem_step;

`ifdef RVV_ALU_SEQ_MASK_EN
    logic              vm_q;
    logic [VLEN/8-1:0] v0_q;
    logic [VLEN/8-1:0] v0_sel;

    assign v0_sel = v0_q >> elem_q;
    // Masked-off element: one idle cycle, no write.
    assign skip = !vm_q && !v0_sel[0];
`else
    assign skip = 1'b0;
`endif

    assign accept  = (state_q == S_IDLE) && start;
    assign bad_sew = (vsew > 3'd3);

    always_comb begin
        vlmax = 11'(VLEN >> (int'(vsew) + 3));
        vle_d = vl;
        if ({1'b0, vl} > vlmax) vle_d = vlmax[9:0];
    end

    assign last_elem = (elem_q == vle_q - 10'd1);
    assign elem_step = skip || (chunk_q == chunk_last_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (bad_sew || vle_d == 10'd0)
                        state_d = S_DONE;
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (elem_step && last_elem)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            elem_q       <= '0;
            vle_q        <= '0;
            chunk_q      <= '0;
            chunk_last_q <= '0;
            opcode_q     <= '0;
            op_type_q    <= '0;
            vsew_q       <= '0;
            err_q        <= 1'b0;
`ifdef RVV_ALU_SEQ_MASK_EN
            vm_q         <= 1'b1;
            v0_q         <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                elem_q       <= '0;
                chunk_q      <= '0;
                vle_q        <= vle_d;
                chunk_last_q <= nch_last(vsew, LANE_WIDTH);
                opcode_q     <= opcode;
                op_type_q    <= op_type;
                vsew_q       <= vsew;
                err_q        <= bad_sew;
`ifdef RVV_ALU_SEQ_MASK_EN
                vm_q         <= vm;
                v0_q         <= v0_mask;
`endif
            end else if (state_q == S_RUN) begin
                // Chunks go back to back, ascending, so the
                // ALU's registered carry chain stays intact.
                if (elem_step) begin
                    chunk_q <= '0;
                    if (!last_elem) elem_q <= elem_q + 10'd1;
                end else begin
                    chunk_q <= chunk_q + 4'd1;
                end
            end
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign err               = done && err_q;
    assign alu_run           = (state_q == S_RUN) && !skip;
    assign alu_opcode        = opcode_q;
    assign alu_op_type       = op_type_q;
    assign alu_vsew          = vsew_q;
    assign alu_byte_i        = elem_q;
    assign alu_in_reg_offset = chunk_q;

    rvv_vd_merge #(
        .VLEN(VLEN)
    ) u_merge (
        .clk        (clk),
        .resetn     (resetn),
        .load       (accept),
        .vd_old     (vd_old),
        .wr_en      (alu_run),
        .wr_cw_log2 (cw_log2(vsew_q, LANE_WIDTH)),
        .wr_data    (alu_vd),
        .wr_index   (alu_index),
        .vd         (vd_out)
    );

endmodule

// File: tb/tb_rvv_alu_seq.sv
// Scoreboard bench for rvv_alu_seq with a behavioural
// lane ALU model driving alu_vd/alu_index.
module tb_rvv_alu_seq;
    import rvv_pkg::*;

    localparam int VLEN = 128;

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic [5:0]      opcode;
    logic [2:0]      op_type;
    logic [2:0]      vsew;
    logic [9:0]      vl;
    logic [VLEN-1:0] vd_old;
    logic            busy, done, err, alu_run;
    logic [VLEN-1:0] vd_out;
    logic [5:0]      alu_opcode;
    logic [2:0]      alu_op_type, alu_vsew;
    logic [9:0]      alu_byte_i;
    logic [3:0]      alu_in_reg_offset;
    logic [63:0]     alu_vd;
    logic [9:0]      alu_index;

    logic [VLEN-1:0] vs1, vs2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [VLEN-1:0] vd;
        logic            err;
        int              cyc;
        string           name;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rvv_alu_seq #(
        .VLEN(VLEN),
        .LANE_WIDTH(3)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .start             (start),
        .opcode            (opcode),
        .op_type           (op_type),
        .vsew              (vsew),
        .vl                (vl),
        .vd_old            (vd_old),
`ifdef RVV_ALU_SEQ_MASK_EN
        .vm                (1'b1),
        .v0_mask           ({(VLEN/8){1'b1}}),
`endif
        .busy              (busy),
        .done              (done),
        .err               (err),
        .vd_out            (vd_out),
        .alu_run           (alu_run),
        .alu_opcode        (alu_opcode),
        .alu_op_type       (alu_op_type),
        .alu_vsew          (alu_vsew),
        .alu_byte_i        (alu_byte_i),
        .alu_in_reg_offset (alu_in_reg_offset),
        .alu_vd            (alu_vd),
        .alu_index         (alu_index)
    );

    function automatic logic [63:0] elem_op(
        input logic [5:0]  opc,
        input int          sew,
        input logic [63:0] a0,
        input logic [63:0] b0
    );
        logic [63:0] m, a, b, r;
        logic signed [63:0] sa, sb;
        m  = (sew >= 64) ? '1 : ((64'd1 << sew) - 64'd1);
        a  = a0 & m;
        b  = b0 & m;
        sa = a[sew-1] ? (a | ~m) : a;
        sb = b[sew-1] ? (b | ~m) : b;
        case (opc)
            OP_VADD:  r = a + b;
            OP_VSUB:  r = a - b;
            OP_VRSUB: r = b - a;
            OP_VMINU: r = (a < b) ? a : b;
            OP_VMIN:  r = (sa < sb) ? a : b;
            OP_VMAXU: r = (a > b) ? a : b;
            OP_VMAX:  r = (sa > sb) ? a : b;
            OP_VAND:  r = a & b;
            OP_VOR:   r = a | b;
            OP_VXOR:  r = a ^ b;
            default:  r = '0;
        endcase
        return r & m;
    endfunction

    // Lane ALU model: 8-bit lane; min/max emit chunks
    // high-first at a reversed index.
    int m_sew, m_e, m_pos;
    logic [63:0] m_res;
    always_comb begin
        m_sew = 8 << ((alu_vsew > 3'd3) ? 0 : int'(alu_vsew));
        m_e   = int'(alu_byte_i);
        m_res = elem_op(alu_opcode, m_sew,
                        64'(vs2 >> (m_e * m_sew)),
                        64'(vs1 >> (m_e * m_sew)));
        m_pos = int'(alu_in_reg_offset);
        if (alu_opcode[5:2] == 4'b0001)
            m_pos = m_sew / 8 - 1 - int'(alu_in_reg_offset);
        if (m_pos < 0) m_pos = 0;
        alu_vd    = m_res >> (m_pos * 8);
        alu_index = 10'(m_e * m_sew + m_pos * 8);
    end

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d", cyc);
            end else begin
                e = exp_q.pop_front();
                if (vd_out !== e.vd) begin
                    errors++;
                    $display("FAIL %s vd got=%h exp=%h",
                             e.name, vd_out, e.vd);
                end
                checks++;
                if (err !== e.err) begin
                    errors++;
                    $display("FAIL %s err got=%b exp=%b",
                             e.name, err, e.err);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s done_cyc got=%0d exp=%0d",
                             e.name, cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(
        input string           name,
        input logic [5:0]      opc,
        input logic [2:0]      sew,
        input logic [9:0]      len,
        input logic [VLEN-1:0] a1,
        input logic [VLEN-1:0] a2,
        input logic [VLEN-1:0] old,
        input logic [VLEN-1:0] exp_vd,
        input logic            exp_err,
        input int              lat,
        input bit              track
    );
        exp_t e;
        @(negedge clk);
        vs1     = a1;
        vs2     = a2;
        opcode  = opc;
        op_type = OPT_VV;
        vsew    = sew;
        vl      = len;
        vd_old  = old;
        start   = 1'b1;
        @(posedge clk);
        #1;
        if (track) begin
            e.vd   = exp_vd;
            e.err  = exp_err;
            e.cyc  = cyc + lat;
            e.name = name;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s timeout busy=%b", name, busy);
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        logic [31:0] flat;
        flat = {busy, done, err, alu_run, alu_opcode,
                alu_op_type, alu_vsew, alu_byte_i,
                alu_in_reg_offset};
        checks++;
        if (flat !== '0 || vd_out !== '0) begin
            errors++;
            $display("FAIL %s ctl got=%h vd=%h exp=0",
                     name, flat, vd_out);
        end
    endtask

    localparam logic [VLEN-1:0] ONES8 = {16{8'h01}};
    localparam logic [VLEN-1:0] RAMP =
        128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [VLEN-1:0] RAMP1 =
        128'h100F0E0D0C0B0A090807060504030201;

    initial begin
        resetn  = 1'b0;
        start   = 1'b0;
        opcode  = '0;
        op_type = '0;
        vsew    = '0;
        vl      = '0;
        vd_old  = '0;
        vs1     = '0;
        vs2     = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        resetn = 1'b1;

        issue("vadd_e8", OP_VADD, 3'd0, 10'd16, ONES8, RAMP,
              '0, RAMP1, 1'b0, 16, 1);
        wait_idle("vadd_e8");

        issue("vadd_e32", OP_VADD, 3'd2, 10'd4,
              {4{32'h1}}, {4{32'hFF}}, '1,
              {4{32'h100}}, 1'b0, 16, 1);
        wait_idle("vadd_e32");

        issue("vminu_e16", OP_VMINU, 3'd1, 10'd8,
              {8{16'h7FFF}}, {8{16'h8000}}, '0,
              {8{16'h7FFF}}, 1'b0, 16, 1);
        wait_idle("vminu_e16");

        issue("vl_clip", OP_VADD, 3'd0, 10'd20, ONES8, RAMP,
              {16{8'h55}}, RAMP1, 1'b0, 16, 1);
        wait_idle("vl_clip");

        issue("vl3_tail", OP_VADD, 3'd0, 10'd3, ONES8, RAMP,
              {16{8'hAA}}, {{13{8'hAA}}, 24'h030201},
              1'b0, 3, 1);
        wait_idle("vl3_tail");

        issue("vl0", OP_VADD, 3'd0, 10'd0, ONES8, RAMP,
              {8{16'hBEEF}}, {8{16'hBEEF}}, 1'b0, 0, 1);
        wait_idle("vl0");

        issue("bad_sew", OP_VADD, 3'd5, 10'd4, ONES8, RAMP,
              {4{32'h12345678}}, {4{32'h12345678}},
              1'b1, 0, 1);
        wait_idle("bad_sew");

        issue("vsub_e64", OP_VSUB, 3'd3, 10'd2,
              {64'd1, 64'd3}, {64'h100000000, 64'd10}, '0,
              {64'hFFFFFFFF, 64'd7}, 1'b0, 16, 1);
        wait_idle("vsub_e64");

        issue("vmax_e32", OP_VMAX, 3'd2, 10'd4,
              {4{32'h3}}, {4{32'hFFFFFFFE}}, '0,
              {4{32'h3}}, 1'b0, 16, 1);
        wait_idle("vmax_e32");

        // Second start while busy must be ignored.
        issue("vand_busy", OP_VAND, 3'd0, 10'd16,
              {16{8'h3C}}, {16{8'hF0}}, '0,
              {16{8'h30}}, 1'b0, 16, 1);
        repeat (3) @(negedge clk);
        opcode = OP_VSUB;
        vsew   = 3'd1;
        vl     = 10'd1;
        vd_old = '1;
        start  = 1'b1;
        repeat (2) @(negedge clk);
        start  = 1'b0;
        wait_idle("vand_busy");

        // Reset mid-run: no done, everything cleared.
        issue("rst_mid", OP_VADD, 3'd0, 10'd16, ONES8, RAMP,
              '0, RAMP1, 1'b0, 16, 0);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);

        issue("after_rst", OP_VXOR, 3'd0, 10'd16,
              {16{8'hFF}}, RAMP, '0,
              ~RAMP, 1'b0, 16, 1);
        wait_idle("after_rst");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending got=%0d exp=0",
                     exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvv_alu_seq.md
# rvv_alu_seq

Sequencer that drives one `rvv_alu` lane instance through a complete vector arithmetic instruction. It walks every active element, and every lane-wide chunk of each element, feeding `byte_i`/`in_reg_offset` to the ALU. It merges each chunk result into a VLEN-bit destination buffer and signals completion. It sits between the vector issue logic and the ALU datapath.

## Interface
Parameters:
- `VLEN`, 128: vector register width in bits.
- `LANE_WIDTH`, 3: log2 of lane bits (lane = 8/16/32/64 bits); must match the driven ALU.

Ports (reset `resetn`, synchronous, active-low; clock `clk`):
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous active-low reset.
- `start`  in  1  instruction request; accepted only when `busy`=0.
- `opcode`  in  6  ALU opcode, latched at accept.
- `op_type`  in  3  VV/VX/VI one-hot, latched.
- `vsew`  in  3  element width code (SEW = 8<<vsew), latched.
- `vl`  in  10  requested element count, latched.
- `vd_old`  in  VLEN  prior destination contents, latched (tail-undisturbed source).
- `busy`  out  1  instruction in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  illegal vsew flag, valid with `done`.
- `vd_out`  out  VLEN  result buffer.
- `alu_run`  out  1  ALU enable.
- `alu_opcode`  out  6  latched opcode.
- `alu_op_type`  out  3  latched op_type.
- `alu_vsew`  out  3  latched vsew.
- `alu_byte_i`  out  10  current element index.
- `alu_in_reg_offset`  out  4  current chunk index.
- `alu_vd`  in  64  ALU result; low CW bits are used.
- `alu_index`  in  10  ALU bit index for the write.

## Operation
- CW (chunk width) = min(2^LANE_WIDTH, SEW).
- NCH (chunks per element) = 1 if vsew+3 <= LANE_WIDTH, else 2^(vsew+3-LANE_WIDTH).
- Effective vl: VLE = min(vl, VLEN/SEW).
- FSM states:
  - IDLE: `busy`=0. On `start`, latch all inputs, clear element and chunk counters, then go to RUN.
    - vsew > 3: go to DONE with `err`=1 and no writes.
    - VLE = 0: go to DONE with no writes.
  - RUN: `alu_run`=1. Drive `alu_byte_i` = element and `alu_in_reg_offset` = chunk. Write `alu_vd[CW-1:0]` into `vd_out[alu_index +: CW]` on the clock edge.
    - The chunk counter increments every cycle and wraps at NCH-1, which increments the element counter.
    - After element VLE-1, chunk NCH-1, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE. `vd_out` holds until the next accept.
- Chunks of one element are issued on consecutive cycles in ascending offset order, with no gaps. The ALU's registered carry and comparison chaining depend on this.
- Min/max opcodes issue the same ascending offsets; the ALU's reversed `alu_index` places the result correctly.
- Elements at or above VLE keep their `vd_old` bits.
- `start` while `busy`=1 is ignored; there is no queueing.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `alu_run`=0, all `alu_*` outputs 0, `vd_out`=0, FSM in IDLE.
- Accept at edge k → RUN for cycles k+1 … k+VLE·NCH → `done` high in cycle k+1+VLE·NCH.
- With VLE=0 or an illegal vsew, `done` is high in cycle k+1.
- `busy` is high from cycle k+1 through the DONE cycle inclusive.
- `start` may be re-asserted in the cycle after DONE.
- `resetn` low mid-instruction: the next edge returns to IDLE, clears all outputs and raises no `done`.

## Configuration
- `RVV_ALU_SEQ_MASK_EN` defined: adds inputs `vm` (1 bit) and `v0_mask` (VLEN/8 bits).
  - When `vm`=0 and `v0_mask[element]`=0, the element takes a single cycle with `alu_run`=0 and no write; its `vd_old` bits stay (mask-undisturbed).
  - Latency becomes the sum over elements of (active ? NCH : 1), plus 1.
- Undefined: no mask ports; every element below VLE is processed.

## Structure
- Shared `rvv_pkg`:
  - FSM state enum (IDLE/RUN/DONE).
  - Opcode constants (vadd=000000, vsub=000010, vrsub=000011, vminu…vmax=0001xx, vand/vor/vxor=0010xx).
  - VV/VX/VI one-hot constants.
  - NCH/CW helper functions.
- Sub-module `rvv_vd_merge` (CW-masked bit-field write into the VLEN buffer at `alu_index`, with `vd_old` load on accept).

## Test plan
- vadd, vsew=0, vl=16, vs1 all 0x01, vs2 bytes 0x00..0x0F → 16 RUN cycles, `done` at k+17, `vd_out` bytes 0x01..0x10.
- vadd, vsew=2, vl=4, vs2 elements 0x000000FF, vs1 0x00000001 → 16 RUN cycles, each element 0x00000100 (carry propagates across chunks, never across elements).
- vminu, vsew=1, vl=8, vs2 = 0x8000, vs1 = 0x7FFF (per element) → every element 0x7FFF, `done` at k+17.
- vl=20, vsew=0 → clipped to 16; vl=3, vsew=0, `vd_old` all 0xAA → bytes 3..15 remain 0xAA, `done` at k+4.
- vl=0 → `done` at k+1 and `vd_out`=`vd_old`. vsew=5 → `err`=1 with `done` at k+1.
- `resetn` low at RUN cycle 5 → IDLE next cycle, all outputs 0, no `done`. `start` during `busy` → ignored.
